mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative RV32M multiply/divide execute unit, directly downstream of the ALU control decoder.
//  Consumes the 11-bit control word, operands a/b; handles the MUL*/DIV*/REM* ops (mulOp bit set).
//  Valid/ready on both sides; stalls the execute stage while busy. Result goes to writeback mux.
// PARAMETERS
//  XLEN  32  operand/result width; iteration counter is $clog2(XLEN)+1 bits
// PORTS
//  clk           in   1     single clock, rising edge
//  rst_n         in   1     reset, asynchronous assert, active-low
//  start_valid   in   1     operation offered this cycle
//  start_ready   out  1     unit can accept (state IDLE)
//  ctrl          in   11    {add,branch,shift,logical,mul,slt,jalr,logicalOrArith,funct3[2:0]}
//  op_a          in   XLEN  rs1 value (multiplicand / dividend)
//  op_b          in   XLEN  rs2 value (multiplier / divisor)
//  flush         in   1     pipeline kill; abandons any operation
//  result_valid  out  1     result held stable until taken
//  result_ready  in   1     consumer takes result
//  result        out  XLEN  rd value
//  busy          out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; start_ready=1, result_valid=0, busy=0, result=0, counter=0.
//  - Accept = start_valid & start_ready & ctrl[6] & !flush; ctrl[6]=0 ignored, no state change.
//  - Latch funct3, operand signs, |a|,|b| per funct3 at accept: 000 MUL, 001 MULH, 010 MULHSU,
//    011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. MULHSU: a signed, b unsigned.
//  - FSM: IDLE -> CALC (accept) -> FIX -> DONE -> IDLE (result_ready).
//  - CALC: XLEN cycles. Mul: shift-add on 2*XLEN accumulator, 1 bit/cycle.
//    Div: restoring, 1 quotient bit/cycle.
//  - FIX: 1 cycle; two's-complement negate per sign rules. Quotient neg iff signs differ;
//    remainder takes dividend sign. Select low/high product half.
//  - Latency: accept at cycle 0 -> result_valid high at cycle XLEN+2 (34 for XLEN=32).
//  - Special cases, IDLE -> DONE, result_valid at cycle 1:
//    divisor 0: DIV/DIVU -> all ones; REM/REMU -> op_a.
//    signed overflow (op_a=0x8000_0000, op_b=-1): DIV -> 0x8000_0000; REM -> 0.
//  - DONE: result_valid=1, result stable; leaves on result_ready; start_ready=0 until IDLE.
//    No accept in the DONE->IDLE exit cycle.
//  - flush: any state -> IDLE next cycle, result_valid=0 next cycle.
//    flush with start_valid: flush wins, no accept. flush with result_ready in DONE: not consumed.
//  - Reset mid-operation: immediate return to reset values; partial state discarded.
// CONFIGURATION
//  MUL_DIV_FAST_MUL_EN defined: MUL* ops use a single-cycle XLENxXLEN (2*XLEN-bit) product.
//    IDLE -> DONE, result_valid at cycle 1.
//  Undefined: all mul ops take the iterative CALC/FIX path (XLEN+2 latency).
//    Divide path is identical either way.
// STRUCTURE
//  Shared package riscv_pkg:
//    CTRL_* bit-index localparams for the 11-bit control word.
//    F3_MUL..F3_REMU funct3 constants.
//    mdu_state_t enum {IDLE,CALC,FIX,DONE}.
//  Sub-module mdu_iter_core: shared accumulator/shift datapath, one mul or div step per cycle.
//    Top keeps FSM, handshakes, sign fixup, special cases.
// TESTING
//  MUL 7*-3 -> result 0xFFFF_FFEB at cycle 34; MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE.
//  MULH 0x8000_0000*0x8000_0000 -> 0x4000_0000; MULHSU -1*0xFFFF_FFFF -> 0xFFFF_FFFF.
//  DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2; all at cycle 34.
//  DIV x/0 -> 0xFFFF_FFFF at cycle 1; REMU 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000; REM -> 0.
//  flush at cycle 10 of DIV -> IDLE at 11, no result_valid; new accept at 11 -> correct result.
//  result_ready low 5 cycles in DONE: result stable, start_valid refused.
//  ctrl[6]=0 offer: ignored. rst_n low mid-CALC: outputs at reset values.
//  MUL_DIV_FAST_MUL_EN on: MUL 7*-3 at cycle 1; DIV timing unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions.
// Contents: bit positions in the 11-bit ALU control word
//   {add,branch,shift,logical,mul,slt,jalr,logicalOrArith,funct3[2:0]},
//   RV32M funct3 encodings, and the mul/div unit state type.
package riscv_pkg;

  localparam int unsigned CTRL_ADD     = 10;
  localparam int unsigned CTRL_BRANCH  = 9;
  localparam int unsigned CTRL_SHIFT   = 8;
  localparam int unsigned CTRL_LOGICAL = 7;
  localparam int unsigned CTRL_MUL     = 6;
  localparam int unsigned CTRL_SLT     = 5;
  localparam int unsigned CTRL_JALR    = 4;
  localparam int unsigned CTRL_LOA     = 3;
  localparam int unsigned CTRL_F3_MSB  = 2;
  localparam int unsigned CTRL_F3_LSB  = 0;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative multiply/divide datapath: one shift-add multiply step or one
// restoring-divide step per cycle on a 2*XLEN accumulator {acc_hi, acc_lo}.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   load          capture mode/operands, clear acc_hi, acc_lo <= init_lo
//   step          perform one iteration
//   div_mode_in   1 = divide, 0 = multiply (captured on load)
//   init_lo       multiplier (mul) or dividend (div) magnitude
//   operand       multiplicand (mul) or divisor (div) magnitude
//   acc_hi/acc_lo mul: product high/low; div: remainder/quotient
module mdu_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode_in,
  input  logic [XLEN-1:0] init_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo
);

  logic            div_mode;
  logic [XLEN-1:0] opnd;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Partial remainder shifted left with the next dividend bit; the extra
    // top bit keeps the trial subtraction exact when acc_hi >= 2^(XLEN-1).
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_mode <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else if (load) begin
      div_mode <= div_mode_in;
      opnd     <= operand;
      acc_hi   <= '0;
      acc_lo   <= init_lo;
    end else if (step) begin
      if (div_mode) begin
        if (!div_diff[XLEN]) begin
          acc_hi <= div_diff[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide execute unit.
// Magnitudes are computed at accept, iterated in mdu_iter_core for XLEN
// cycles, then sign-corrected in a single fixup cycle. Divide-by-zero and
// signed overflow complete immediately.
// Optional: define MUL_DIV_FAST_MUL_EN for a single-cycle multiplier.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start_valid/start_ready     operation handshake (ready only in IDLE)
//   ctrl[10:0]                  ALU control word; ctrl[6] selects mul/div
//   op_a, op_b                  rs1 / rs2 values
//   flush                       abandon any operation, return to IDLE
//   result_valid/result_ready   result handshake, result held until taken
//   result                      rd value
//   busy                        unit not IDLE
module mul_div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [10:0]     ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  mdu_state_t      state;
  logic [2:0]      f3;
  logic            neg;
  logic [CW-1:0]   count;

  logic [2:0]      in_f3;
  logic            in_div, a_signed, b_signed, sa, sb, neg_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            accept, special, go_iter;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic [XLEN-1:0] div_val, fix_res;
  logic            ctrl_unused;

  assign ctrl_unused = ^{ctrl[10:7], ctrl[5:3]};

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag,
                                               input logic neg_p,
                                               input logic [2:0] f);
    logic [2*XLEN-1:0] p;
    p = neg_p ? -mag : mag;
    return (f == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    in_f3    = ctrl[CTRL_F3_MSB:CTRL_F3_LSB];
    in_div   = in_f3[2];
    a_signed = (in_f3 == F3_MUL) || (in_f3 == F3_MULH) || (in_f3 == F3_MULHSU) ||
               (in_f3 == F3_DIV) || (in_f3 == F3_REM);
    b_signed = (in_f3 == F3_MUL) || (in_f3 == F3_MULH) ||
               (in_f3 == F3_DIV) || (in_f3 == F3_REM);
    sa       = a_signed & op_a[XLEN-1];
    sb       = b_signed & op_b[XLEN-1];
    mag_a    = sa ? -op_a : op_a;
    mag_b    = sb ? -op_b : op_b;
    // Remainder follows the dividend; quotient and product follow sign parity.
    neg_in   = (in_f3 == F3_REM || in_f3 == F3_REMU) ? sa : (sa ^ sb);
    accept   = start_valid & start_ready & ctrl[CTRL_MUL] & ~flush;

    special     = 1'b0;
    special_res = '0;
    if (in_div && op_b == '0) begin
      special     = 1'b1;
      special_res = in_f3[1] ? op_a : '1;
    end else if ((in_f3 == F3_DIV || in_f3 == F3_REM) &&
                 op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1) begin
      special     = 1'b1;
      special_res = in_f3[1] ? '0 : op_a;
    end

`ifdef MUL_DIV_FAST_MUL_EN
    go_iter = accept & ~special & in_div;
`else
    go_iter = accept & ~special;
`endif

    div_val = f3[1] ? acc_hi : acc_lo;
    fix_res = f3[2] ? (neg ? -div_val : div_val)
                    : mul_pick({acc_hi, acc_lo}, neg, f3);
  end

`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (go_iter),
    .step        (state == CALC && !flush),
    .div_mode_in (in_div),
    .init_lo     (in_div ? mag_a : mag_b),
    .operand     (in_div ? mag_b : mag_a),
    .acc_hi      (acc_hi),
    .acc_lo      (acc_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      f3     <= '0;
      neg    <= 1'b0;
      count  <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          f3    <= in_f3;
          neg   <= neg_in;
          count <= '0;
          if (special) begin
            result <= special_res;
            state  <= DONE;
          end
`ifdef MUL_DIV_FAST_MUL_EN
          else if (!in_div) begin
            result <= mul_pick(fast_prod, neg_in, in_f3);
            state  <= DONE;
          end
`endif
          else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (count == CW'(XLEN - 1)) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + 1'b1;
          end
        end
        FIX: begin
          result <= fix_res;
          state  <= DONE;
        end
        DONE: if (result_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [10:0] ctrl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int passed = 0;
  int total  = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .ctrl         (ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; q = sa / sb; return q[31:0]; end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MUL_DIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [10:0] mk_ctrl(input logic [2:0] f);
    logic [10:0] c;
    c = '0;
    c[6] = 1'b1;
    c[2:0] = f;
    return c;
  endfunction

  // Offer one op at the next edge, wait for the result (bounded), check it.
  // hold > 0 keeps result_ready low that many cycles while offering another op.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat;
    exp = model(f, a, b);
    @(negedge clk);
    start_valid = 1'b1; ctrl = mk_ctrl(f); op_a = a; op_b = b;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!result_valid && lat < 100);
    check($sformatf("%s latency", tag), lat, model_lat(f, a, b));
    check($sformatf("%s result", tag), result, exp);
    if (!result_valid) begin
      flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
      return;
    end
    if (hold > 0) begin
      start_valid = 1'b1; ctrl = mk_ctrl(3'd0); op_a = 32'd3; op_b = 32'd3;
      repeat (hold) begin
        @(negedge clk);
        check($sformatf("%s hold result", tag), result, exp);
        check($sformatf("%s hold valid", tag), {31'b0, result_valid}, 32'd1);
        check($sformatf("%s hold start_ready", tag), {31'b0, start_ready}, 32'd0);
      end
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    check($sformatf("%s back idle busy", tag), {31'b0, busy}, 32'd0);
    start_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0] rf;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset start_ready", {31'b0, start_ready}, 32'd1);
    check("reset result_valid", {31'b0, result_valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("MULHU max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 0);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 0);
    run_op("DIV x/0", 3'd4, 32'd1234, 32'd0, 0);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("DIVU max/1", 3'd5, 32'hFFFF_FFFF, 32'd1, 0);

    // Result held while consumer stalls; offers refused
    run_op("hold DIVU", 3'd5, 32'd1000, 32'd9, 5);

    // Flush at cycle 10 of a DIV, with a competing offer
    @(negedge clk);
    start_valid = 1'b1; ctrl = mk_ctrl(3'd4); op_a = 32'd500; op_b = 32'd7;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("flush pre valid", {31'b0, result_valid}, 32'd0);
    end
    flush = 1'b1; start_valid = 1'b1; ctrl = mk_ctrl(3'd0);
    @(negedge clk);
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush result_valid", {31'b0, result_valid}, 32'd0);
    check("flush start_ready", {31'b0, start_ready}, 32'd1);
    flush = 1'b0; start_valid = 1'b0;
    run_op("post-flush DIV", 3'd4, 32'hFFFF_FC18, 32'd7, 0);

    // Non-mul control word is ignored
    @(negedge clk);
    start_valid = 1'b1; ctrl = 11'b100_0000_1000; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(negedge clk);
    check("non-mul busy", {31'b0, busy}, 32'd0);
    check("non-mul start_ready", {31'b0, start_ready}, 32'd1);

    // Randomized operations with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf, ra, rb), rf, ra, rb, 0);
    end

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start_valid = 1'b1; ctrl = mk_ctrl(3'd5); op_a = 32'd77; op_b = 32'd5;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", {31'b0, busy}, 32'd0);
    check("async reset start_ready", {31'b0, start_ready}, 32'd1);
    check("async reset result_valid", {31'b0, result_valid}, 32'd0);
    check("async reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
